wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the pipelined MIPS core: the write side of the register-file path whose read side is the decode stage. It accepts retiring instructions from the EX/MEM boundary and waits for load data from data memory with a bounded timeout. It extracts and extends sub-word loads, then drives the register file's single write port (`RegWrite`, `WrAddr`, `WrData`) for exactly one cycle per retiring write.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: maximum cycles spent in WAIT_MEM before abort (1..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: EX/MEM presents a retiring instruction.
- `in_ready` out 1: stage can accept; high in IDLE and WRITE.
- `in_RegWrite` in 1: instruction writes a register.
- `in_MemtoReg` in 1: 1 = write data comes from memory (load); 0 = from ALU.
- `in_wr_addr` in 5: destination register, already Rd/Rt-selected upstream.
- `in_alu_result` in 32: ALU result; for loads, the byte address (bits [1:0] = byte offset).
- `in_ld_type` in 3: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 treated as lw.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `mem_rdata` in 32: aligned word read from data memory.
- `RegWrite` out 1: register-file write enable, registered.
- `WrAddr` out 5: register-file write address, registered.
- `WrData` out 32: register-file write data, registered.
- `busy` out 1: high in WAIT_MEM; the hazard unit uses it to stall.
- `err_align` out 1: sticky misaligned-load flag.
- `err_timeout` out 1: sticky memory-timeout flag.
- `retired_cnt` out 16: count of register writes performed; wraps 0xFFFF→0.

## Operation
- States: IDLE, WAIT_MEM, WRITE. `in_ready = (state != WAIT_MEM)`.
- Accept rule: accept when `in_valid && in_ready`. On accept, latch `wr_addr`, `alu_result`, `ld_type` and the control bits.
- Accepted with `in_RegWrite=0` (store, branch): go to IDLE; no write.
- Accepted with `in_RegWrite=1`, `in_MemtoReg=0`: go to WRITE; data = `alu_result`.
- Accepted with `in_RegWrite=1`, `in_MemtoReg=1`:
  - Go to WAIT_MEM and clear the timeout counter.
  - `mem_rvalid` is ignored outside WAIT_MEM.
- WAIT_MEM, `mem_rvalid=1`: extract the data and go to WRITE. On misalignment, set `err_align` and go to IDLE without writing.
- WAIT_MEM, no `mem_rvalid`: the counter increments. When it reaches `MEM_TIMEOUT`, set `err_timeout` and go to IDLE without writing.
- WRITE: `RegWrite=1` for this cycle only. If there is no new accept, go to IDLE; otherwise apply the accept rule, allowing back-to-back writes.
- `$0` rule: when the latched `wr_addr==0`, the stage still traverses WRITE but `RegWrite` stays 0 and `retired_cnt` does not increment.
- `retired_cnt` increments on each cycle with `RegWrite=1`.
- Load extraction (little-endian, off = `alu_result[1:0]`):
  - lw: requires off==0; data = `rdata`.
  - lh/lhu: requires off[0]==0. Halfword = `rdata[15:0]` when off[1]=0, `rdata[31:16]` when off[1]=1; sign-extended (lh) or zero-extended (lhu).
  - lb/lbu: byte = `rdata[8*off+7 : 8*off]`; sign-extended (lb) or zero-extended (lbu).
- Error flags are sticky; only `rst` clears them.

## Timing
- Reset (async): state IDLE, `RegWrite=0`, `WrAddr=0`, `WrData=0`, `busy=0`, `err_align=0`, `err_timeout=0`, `retired_cnt=0`, `in_ready=1`.
- Reset mid-load: abandon immediately; no write occurs and the pending data is lost.
- ALU write: accepted at edge N; `RegWrite`/`WrAddr`/`WrData` valid during cycle N+1.
- Load write: `mem_rvalid` sampled at edge M (in WAIT_MEM); write valid during cycle M+1.
- Minimum load latency: accepted at N, `mem_rvalid` at N+1, write in cycle N+2.
- Timeout: with no `rvalid`, WAIT_MEM lasts `MEM_TIMEOUT` cycles, then IDLE. `err_timeout` rises on the same edge that leaves WAIT_MEM.
- `rvalid` arriving on the same edge the counter hits `MEM_TIMEOUT`: data wins; write, no error.
- Register-file write happens at the end of the WRITE cycle. Same-cycle decode reads of that register see the old value; the forwarding unit is responsible for this.

## Test plan
- ALU op, addr 8, result 0x12345678, accepted cycle 0 → cycle 1: `RegWrite=1`, `WrAddr=8`, `WrData=0x12345678`; cycle 2: `RegWrite=0`; `retired_cnt=1`.
- lb, addr 0x...03, `rdata=0x80FF7F01`, `rvalid` two cycles after accept → `WrData=0xFFFFFF80`; the same case with lbu → `0x00000080`; `busy=1` while waiting.
- lh at offset 1 → no write, `err_align=1`, state back to IDLE; a following lhu at offset 2 on `rdata=0xBEEF0000` → `WrData=0x0000BEEF`.
- Load with no `rvalid`, `MEM_TIMEOUT=15` → `busy` high for 15 cycles, then `err_timeout=1` and no write; a late `rvalid` is ignored.
- Three back-to-back ALU ops (addrs 1, 0, 2) → `RegWrite` pattern 1,0,1 on consecutive cycles; `retired_cnt=2`.
- `rst` asserted while in WAIT_MEM, then `rvalid` → all outputs 0 asynchronously, no write; `retired_cnt` wraps 0xFFFF→0 after one further write.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of the pipelined MIPS core.
//
// Takes retiring instructions from the EX/MEM boundary. ALU results go
// straight to the register-file write port. Loads wait in WAIT_MEM for
// memory read data, which is extracted and extended for sub-word loads.
// The wait has a bounded timeout. Each retiring write drives RegWrite
// for exactly one cycle.
//
// Handshake: an instruction is accepted on a rising edge where
// in_valid && in_ready. in_ready is low only while a load waits for
// memory. mem_rvalid is a one-cycle strobe that is looked at only in
// WAIT_MEM.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready accept handshake from EX/MEM
//   in_RegWrite       instruction writes a register
//   in_MemtoReg       1 = load (data from memory), 0 = ALU result
//   in_wr_addr        destination register
//   in_alu_result     ALU result; byte address for loads
//   in_ld_type        000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others lw
//   mem_rvalid        mem_rdata valid this cycle
//   mem_rdata         aligned word from data memory
//   RegWrite/WrAddr/WrData  registered register-file write port
//   busy              high while waiting on memory (pipeline stall)
//   err_align         sticky misaligned-load flag
//   err_timeout       sticky memory-timeout flag
//   retired_cnt       count of register writes performed (wraps)
//   state_dbg         current FSM state (0 IDLE, 1 WAIT_MEM, 2 WRITE)

module wb_stage #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_RegWrite,
    input  logic        in_MemtoReg,
    input  logic [4:0]  in_wr_addr,
    input  logic [31:0] in_alu_result,
    input  logic [2:0]  in_ld_type,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        RegWrite,
    output logic [4:0]  WrAddr,
    output logic [31:0] WrData,
    output logic        busy,
    output logic        err_align,
    output logic        err_timeout,
    output logic [15:0] retired_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    // Counter value at which a cycle without rvalid ends the wait.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [4:0]  lat_addr;
    logic [1:0]  lat_off;
    logic [2:0]  lat_ld_type;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        ld_misaligned;

    assign in_ready  = (state != WAIT_MEM);
    assign busy      = (state == WAIT_MEM);
    assign state_dbg = state;

    // Little-endian sub-word extraction from the aligned memory word.
    always_comb begin
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase

        ld_data       = mem_rdata;
        ld_misaligned = (lat_off != 2'd0);
        case (lat_ld_type)
            3'b001: begin
                ld_data       = {{16{ld_half[15]}}, ld_half};
                ld_misaligned = lat_off[0];
            end
            3'b010: begin
                ld_data       = {16'h0000, ld_half};
                ld_misaligned = lat_off[0];
            end
            3'b011: begin
                ld_data       = {{24{ld_byte[7]}}, ld_byte};
                ld_misaligned = 1'b0;
            end
            3'b100: begin
                ld_data       = {24'h000000, ld_byte};
                ld_misaligned = 1'b0;
            end
            default: ;  // lw, including the unused encodings
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= 8'd0;
            lat_addr    <= 5'd0;
            lat_off     <= 2'd0;
            lat_ld_type <= 3'd0;
            RegWrite    <= 1'b0;
            WrAddr      <= 5'd0;
            WrData      <= 32'd0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            retired_cnt <= 16'd0;
        end else begin
            // The write enable is a single-cycle pulse; the count follows
            // the cycle in which the pulse was high.
            RegWrite <= 1'b0;
            if (RegWrite) begin
                retired_cnt <= retired_cnt + 16'd1;
            end

            case (state)
                IDLE, WRITE: begin
                    if (in_valid) begin
                        lat_addr    <= in_wr_addr;
                        lat_off     <= in_alu_result[1:0];
                        lat_ld_type <= in_ld_type;
                        if (!in_RegWrite) begin
                            state <= IDLE;
                        end else if (!in_MemtoReg) begin
                            state    <= WRITE;
                            // $0 still passes through WRITE but never writes.
                            RegWrite <= (in_wr_addr != 5'd0);
                            WrAddr   <= in_wr_addr;
                            WrData   <= in_alu_result;
                        end else begin
                            state   <= WAIT_MEM;
                            tmo_cnt <= 8'd0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                WAIT_MEM: begin
                    // Data arriving on the timeout edge takes priority.
                    if (mem_rvalid) begin
                        if (ld_misaligned) begin
                            err_align <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state    <= WRITE;
                            RegWrite <= (lat_addr != 5'd0);
                            WrAddr   <= lat_addr;
                            WrData   <= ld_data;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed cases plus randomized ALU/load traffic,
// checked against a transaction-level reference model and a write scoreboard.

module tb_wb_stage;

  localparam int TMO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_RegWrite, in_MemtoReg;
  logic [4:0]  in_wr_addr;
  logic [31:0] in_alu_result;
  logic [2:0]  in_ld_type;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic        busy, err_align, err_timeout;
  logic [15:0] retired_cnt;
  logic [1:0]  state_dbg;

  wb_stage #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_wr_addr(in_wr_addr), .in_alu_result(in_alu_result),
    .in_ld_type(in_ld_type),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .WrAddr(WrAddr), .WrData(WrData),
    .busy(busy), .err_align(err_align), .err_timeout(err_timeout),
    .retired_cnt(retired_cnt), .state_dbg(state_dbg)
  );

  // ---------------- reference model state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [36:0] exp_q[$];          // {addr, data} of expected writes, in order
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_err_align = 1'b0;
  logic        exp_err_tmo   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Load semantics: returns {ok, data}.
  function automatic logic [32:0] ref_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'd1:    return {off[0] == 1'b0, 32'($signed(h))};
      3'd2:    return {off[0] == 1'b0, 32'(h)};
      3'd3:    return {1'b1, 32'($signed(b))};
      3'd4:    return {1'b1, 32'(b)};
      default: return {off == 2'd0, w};
    endcase
  endfunction

  function automatic void expect_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      exp_q.push_back({a, d});
      exp_cnt = exp_cnt + 16'd1;
    end
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(RegWrite), 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(WrAddr), 32'(e[36:32]));
        check("wr_data", WrData, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_RegWrite = 1'b0;
    in_MemtoReg = 1'b0;
    mem_rvalid  = 1'b0;
  endtask

  // One cycle without RegWrite, then flags/counter against the model.
  task automatic settle();
    @(negedge clk);
    check("we_drop", 32'(RegWrite), 32'd0);
    @(negedge clk);
    check("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
    check("err_align", 32'(err_align), 32'(exp_err_align));
    check("err_timeout", 32'(err_timeout), 32'(exp_err_tmo));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
  endtask

  // ALU op (we=1) or store/branch (we=0); memory noise must be ignored.
  task automatic do_alu(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    in_valid      = 1'b1;
    in_RegWrite   = we;
    in_MemtoReg   = 1'b0;
    in_wr_addr    = a;
    in_alu_result = d;
    in_ld_type    = 3'($urandom_range(0, 7));
    mem_rvalid    = 1'($urandom_range(0, 1));
    mem_rdata     = $urandom;
    if (we) expect_write(a, d);
    @(negedge clk);
    check("alu_we", 32'(RegWrite), 32'(we && (a != 5'd0)));
    idle_inputs();
  endtask

  // Load with rvalid sampled dly cycles after the accepting edge.
  task automatic do_load(input logic [4:0] a, input logic [1:0] off, input logic [2:0] t,
                         input logic [31:0] w, input int dly);
    logic [32:0] r;
    logic        wrote;
    r = ref_load(t, off, w);
    wrote = (dly <= TMO) && r[32] && (a != 5'd0);
    @(negedge clk);
    in_valid      = 1'b1;
    in_RegWrite   = 1'b1;
    in_MemtoReg   = 1'b1;
    in_wr_addr    = a;
    in_alu_result = {$urandom_range(0, 32'h3FFF_FFFF), off};
    in_ld_type    = t;
    mem_rvalid    = 1'($urandom_range(0, 1));   // sampled in IDLE: ignored
    mem_rdata     = $urandom;
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      check("ld_busy", 32'(busy), 32'(k <= TMO));
      check("ld_ready", 32'(in_ready), 32'(k > TMO));
      if (k == dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = w;
        if (dly > TMO) exp_err_tmo = 1'b1;
        else if (!r[32]) exp_err_align = 1'b1;
        else expect_write(a, r[31:0]);
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("ld_we", 32'(RegWrite), 32'(wrote));
    check("ld_err_align", 32'(err_align), 32'(exp_err_align));
    check("ld_err_timeout", 32'(err_timeout), 32'(exp_err_tmo));
  endtask

  function automatic void model_reset();
    exp_q.delete();
    exp_cnt       = 16'd0;
    exp_err_align = 1'b0;
    exp_err_tmo   = 1'b0;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] bb_addr[3];
    idle_inputs();
    in_wr_addr    = 5'd0;
    in_alu_result = 32'd0;
    in_ld_type    = 3'd0;
    mem_rdata     = 32'd0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_we", 32'(RegWrite), 32'd0);
    check("rst_addr", 32'(WrAddr), 32'd0);
    check("rst_data", WrData, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_cnt", 32'(retired_cnt), 32'd0);
    check("rst_err_align", 32'(err_align), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // plain ALU write
    do_alu(1'b1, 5'd8, 32'h1234_5678);
    settle();

    // sub-word loads, rvalid two cycles after accept
    do_load(5'd9, 2'd3, 3'd3, 32'h80FF_7F01, 2);          // lb  -> FFFFFF80
    settle();
    do_load(5'd9, 2'd3, 3'd4, 32'h80FF_7F01, 2);          // lbu -> 00000080
    settle();
    do_load(5'd10, 2'd1, 3'd1, 32'h1234_5678, 1);         // lh misaligned
    settle();
    do_load(5'd10, 2'd2, 3'd2, 32'hBEEF_0000, 1);         // lhu -> 0000BEEF
    settle();
    do_load(5'd11, 2'd0, 3'd0, 32'hCAFE_F00D, 1);         // lw, minimum latency
    settle();
    do_load(5'd12, 2'd0, 3'd0, 32'h0BAD_CAFE, TMO);       // rvalid on timeout edge
    settle();
    do_load(5'd13, 2'd0, 3'd0, 32'hDEAD_BEEF, TMO + 3);   // timeout, late rvalid
    settle();

    // back-to-back ALU ops to 1, 0 ($0), 2
    bb_addr[0] = 5'd1;
    bb_addr[1] = 5'd0;
    bb_addr[2] = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) check("b2b_we", 32'(RegWrite), 32'(bb_addr[i-1] != 5'd0));
      in_valid      = 1'b1;
      in_RegWrite   = 1'b1;
      in_MemtoReg   = 1'b0;
      in_wr_addr    = bb_addr[i];
      in_alu_result = 32'hA000_0000 + 32'(i);
      expect_write(bb_addr[i], 32'hA000_0000 + 32'(i));
    end
    @(negedge clk);
    check("b2b_we", 32'(RegWrite), 32'(bb_addr[2] != 5'd0));
    idle_inputs();
    settle();

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)
        do_alu(1'b1, 5'($urandom_range(0, 31)), $urandom);
      else if (sel == 4)
        do_alu(1'b0, 5'($urandom_range(0, 31)), $urandom);
      else
        do_load(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), $urandom, $urandom_range(1, TMO + 2));
      settle();
    end

    // reset while waiting on memory
    @(negedge clk);
    in_valid    = 1'b1;
    in_RegWrite = 1'b1;
    in_MemtoReg = 1'b1;
    in_wr_addr  = 5'd7;
    in_alu_result = 32'h0000_0000;
    in_ld_type  = 3'd0;
    @(negedge clk);
    idle_inputs();
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_we", 32'(RegWrite), 32'd0);
    check("arst_addr", 32'(WrAddr), 32'd0);
    check("arst_data", WrData, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_cnt", 32'(retired_cnt), 32'd0);
    check("arst_err_align", 32'(err_align), 32'd0);
    check("arst_err_timeout", 32'(err_timeout), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    settle();

    // counter wrap: 0xFFFF back-to-back writes, then one more
    for (int i = 0; i < 65535; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      @(negedge clk);
      in_valid      = 1'b1;
      in_RegWrite   = 1'b1;
      in_MemtoReg   = 1'b0;
      in_wr_addr    = a;
      in_alu_result = d;
      expect_write(a, d);
    end
    @(negedge clk);
    idle_inputs();
    settle();
    check("cnt_ffff", 32'(retired_cnt), 32'h0000_FFFF);
    do_alu(1'b1, 5'd3, 32'h0000_0042);
    settle();
    check("cnt_wrap", 32'(retired_cnt), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
